// File: rtl/sprite_ram_loader_pkg.sv
// ---------------------------------------------------------------------------
// sprite_ram_loader_pkg
//   Sprite geometry, blanking boundary, pixel width and loader FSM state
//   encodings. The HDMI compositor reads the same sprite constants, so a
//   change to the sprite size here moves both sides of the sprite RAM.
// ---------------------------------------------------------------------------
package sprite_ram_loader_pkg;

    localparam int SPRITE_W = 64;
    localparam int SPRITE_H = 64;
    localparam int ADDR_W   = 12;
    localparam int V_ACTIVE = 480;
    localparam int RGB_W    = 24;
    localparam int Y_W      = 10;

    localparam int COL_W    = $clog2(SPRITE_W);
    localparam int ROW_W    = $clog2(SPRITE_H);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BLANK = 2'd1,
        LOAD       = 2'd2,
        DONE       = 2'd3
    } loader_state_t;

endpackage

// File: rtl/sprite_ram_loader.sv
// ---------------------------------------------------------------------------
// sprite_ram_loader
//   Write side of the sprite pixel store. Takes a ready/valid stream of RGB
//   pixels and writes them row-major into the dual-port sprite RAM, but only
//   while the display is in vertical blanking, so the compositor never shows
//   a half-written sprite. A load that runs out of blanking pauses and picks
//   up at the same address in the next blanking interval.
//
// Ports
//   clk_25mhz  in   pixel clock, all logic on the rising edge
//   reset      in   synchronous, active-high
//   start      in   pulse: load one full sprite (ignored unless idle)
//   y          in   current scanline from the video timing generator
//   in_valid   in   source pixel valid
//   in_data    in   source pixel {R,G,B}
//   in_ready   out  pixel is accepted this cycle when in_valid is also high
//   wr_en      out  RAM write strobe (one cycle after the accept)
//   wr_addr    out  RAM write address {row, col}
//   wr_data    out  RAM write data
//   busy       out  load requested and not yet finished
//   done       out  one-cycle pulse alongside the last pixel's write
// ---------------------------------------------------------------------------
module sprite_ram_loader (
    input  logic              clk_25mhz,
    input  logic              reset,
    input  logic              start,
    input  logic [9:0]        y,
    input  logic              in_valid,
    input  logic [23:0]       in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [11:0]       wr_addr,
    output logic [23:0]       wr_data,
    output logic              busy,
    output logic              done
);

    import sprite_ram_loader_pkg::*;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPRITE_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SPRITE_H - 1);

    loader_state_t    state;
    loader_state_t    state_nxt;
    logic             blank_q;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             accept;
    logic             last_pixel;

    // Registered blanking flag. Both the FSM and in_ready use this one copy so
    // the loader can never accept a pixel in a cycle it also decides to pause.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            blank_q <= 1'b0;
        end else begin
            blank_q <= (y >= Y_W'(V_ACTIVE));
        end
    end

    assign in_ready   = (state == LOAD) && blank_q;
    assign accept     = in_valid && in_ready;
    assign last_pixel = (row == ROW_LAST) && (col == COL_LAST);
    assign busy       = (state == WAIT_BLANK) || (state == LOAD);
    assign done       = (state == DONE);

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Leaving LOAD on a blanking drop cannot lose a pixel: in_ready is already
    // low in that cycle, so the accept and the pause are mutually exclusive.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = WAIT_BLANK;
                end
            end
            WAIT_BLANK: begin
                if (blank_q) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (accept && last_pixel) begin
                    state_nxt = DONE;
                end else if (!blank_q) begin
                    state_nxt = WAIT_BLANK;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Row/column position of the next pixel. Counters only move on an accept,
    // so a paused load resumes exactly where it stopped.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (last_pixel) begin
                col <= '0;
                row <= '0;
            end else if (col == COL_LAST) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // One-cycle registered write port. Address and data hold their last value
    // between writes; only wr_en qualifies them.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_addr <= {row, col};
                wr_data <= in_data;
            end
        end
    end

endmodule
